mdu_hilo_ctrl: RTL and testbench

MDU_HILO_CTRL -- requirements
Module: mdu_hilo_ctrl

---
 rtl/mdu_hilo_ctrl_pkg.sv | 22 ++
 rtl/mdu_hilo_ctrl_counter.sv | 43 ++++
 rtl/mdu_hilo_ctrl.sv | 142 ++++++++++++++
 tb/tb_mdu_hilo_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_hilo_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply-divide controller.
// Holds the FSM state encoding, the op-select values and the default divider latency.
package mdu_hilo_ctrl_pkg;

   // Width of the latency down-counter; the divider latency must fit in it.
   localparam int unsigned CntWidth = 6;

   // Default number of edges from operand sampling to a valid quotient.
   localparam int unsigned DivLatencyDefault = 34;

   // Op select carried on iOperation / oMduOperation.
   localparam logic OpMul = 1'b0;
   localparam logic OpDiv = 1'b1;

   typedef enum logic [1:0] {
      StIdle    = 2'b00,
      StMulWait = 2'b01,
      StDivWait = 2'b10,
      StDone    = 2'b11
   } state_e;

endpackage

// File: rtl/mdu_hilo_ctrl_counter.sv
// mdu_latency_counter: loadable saturating down-counter used to time MDU results.
// Ports:
//   iClk, iReset : clock, synchronous active-high reset (count -> 0)
//   iLoad        : load iValue into the counter (takes priority over iDec)
//   iValue       : load value
//   iDec         : decrement by one; holds at zero rather than wrapping
//   oCount       : current count
//   oZero        : count equals zero
module mdu_latency_counter
   import mdu_hilo_ctrl_pkg::*;
(
   input  logic                iClk,
   input  logic                iReset,
   input  logic                iLoad,
   input  logic [CntWidth-1:0] iValue,
   input  logic                iDec,
   output logic [CntWidth-1:0] oCount,
   output logic                oZero
);

   logic [CntWidth-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (iLoad) begin
         cnt_d = iValue;
      end else if (iDec && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge iClk) begin
      if (iReset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign oCount = cnt_q;
   assign oZero  = (cnt_q == '0);

endmodule

// File: rtl/mdu_hilo_ctrl.sv
// HI/LO register controller for an external multiply/divide unit.
// Latches operands for the MDU, waits a fixed latency, then captures the MDU
// result into HI (multiply) or LO (divide). Also accepts direct HI/LO writes.
// Ports:
//   iClk, iReset            : clock, synchronous active-high reset
//   iStart, iOperation      : op request and select (0 = multiply, 1 = divide)
//   iSrcA, iSrcB            : operands
//   iMoveToHi/Lo, iMoveData : direct writes to HI/LO (only when not busy)
//   oMduSrc0/1, oMduOperation : held operands/op toward the MDU
//   iMduResult              : MDU result
//   oHi, oLo                : architectural HI/LO
//   oBusy                   : stall request while waiting on the MDU
//   oDone                   : one-cycle completion pulse
module mdu_hilo_ctrl
   import mdu_hilo_ctrl_pkg::*;
#(
   parameter int unsigned DIV_LATENCY = DivLatencyDefault
) (
   input  logic        iClk,
   input  logic        iReset,
   input  logic        iStart,
   input  logic        iOperation,
   input  logic [31:0] iSrcA,
   input  logic [31:0] iSrcB,
   input  logic        iMoveToHi,
   input  logic        iMoveToLo,
   input  logic [31:0] iMoveData,
   output logic [31:0] oMduSrc0,
   output logic [31:0] oMduSrc1,
   output logic        oMduOperation,
   input  logic [31:0] iMduResult,
   output logic [31:0] oHi,
   output logic [31:0] oLo,
   output logic        oBusy,
   output logic        oDone
);

   localparam logic [CntWidth-1:0] DivLoad = CntWidth'(DIV_LATENCY);
   localparam logic [CntWidth-1:0] MulLoad = CntWidth'(1);

   state_e      state_d, state_q;
   logic [31:0] src0_d, src0_q;
   logic [31:0] src1_d, src1_q;
   logic        op_d, op_q;
   logic [31:0] hi_d, hi_q;
   logic [31:0] lo_d, lo_q;

   logic                busy;
   logic                accept;
   logic                cnt_zero;
   logic [CntWidth-1:0] cnt_load_val;
   logic [CntWidth-1:0] cnt_value;

   assign busy   = (state_q == StMulWait) || (state_q == StDivWait);
   assign accept = iStart && !busy;

   assign cnt_load_val = (iOperation == OpDiv) ? DivLoad : MulLoad;

   mdu_latency_counter u_counter (
      .iClk   (iClk),
      .iReset (iReset),
      .iLoad  (accept),
      .iValue (cnt_load_val),
      .iDec   (busy),
      .oCount (cnt_value),
      .oZero  (cnt_zero)
   );

   always_comb begin
      state_d = state_q;
      src0_d  = src0_q;
      src1_d  = src1_q;
      op_d    = op_q;
      hi_d    = hi_q;
      lo_d    = lo_q;

      // Moves first so that a capture in the same cycle (never possible, since
      // moves require !busy) or a later capture overwrites them.
      if (!busy && iMoveToHi) hi_d = iMoveData;
      if (!busy && iMoveToLo) lo_d = iMoveData;

      if (accept) begin
         src0_d = iSrcA;
         src1_d = iSrcB;
         op_d   = iOperation;
      end

      unique case (state_q)
         StIdle, StDone: begin
            if (accept) begin
               state_d = (iOperation == OpDiv) ? StDivWait : StMulWait;
            end else begin
               state_d = StIdle;
            end
         end
         StMulWait: begin
            if (cnt_zero) begin
               hi_d    = iMduResult;
               state_d = StDone;
            end
         end
         StDivWait: begin
            if (cnt_zero) begin
               lo_d    = iMduResult;
               state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge iClk) begin
      if (iReset) begin
         state_q <= StIdle;
         src0_q  <= '0;
         src1_q  <= '0;
         op_q    <= OpMul;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         src0_q  <= src0_d;
         src1_q  <= src1_d;
         op_q    <= op_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign oMduSrc0      = src0_q;
   assign oMduSrc1      = src1_q;
   assign oMduOperation = op_q;
   assign oHi           = hi_q;
   assign oLo           = lo_q;
   assign oBusy         = busy;
   assign oDone         = (state_q == StDone);

   // Count value is only observed through the zero flag.
   logic unused_cnt;
   assign unused_cnt = ^cnt_value;

endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// Directed self-checking bench for mdu_hilo_ctrl with a behavioural MDU model.
module tb_mdu_hilo_ctrl;

   logic        iClk = 1'b0;
   logic        iReset;
   logic        iStart;
   logic        iOperation;
   logic [31:0] iSrcA, iSrcB;
   logic        iMoveToHi, iMoveToLo;
   logic [31:0] iMoveData;
   logic [31:0] oMduSrc0, oMduSrc1;
   logic        oMduOperation;
   logic [31:0] iMduResult;
   logic [31:0] oHi, oLo;
   logic        oBusy, oDone;

   int n_checks = 0;
   int n_bad    = 0;

   always #5 iClk = ~iClk;

   mdu_hilo_ctrl #(.DIV_LATENCY(34)) dut (
      .iClk          (iClk),
      .iReset        (iReset),
      .iStart        (iStart),
      .iOperation    (iOperation),
      .iSrcA         (iSrcA),
      .iSrcB         (iSrcB),
      .iMoveToHi     (iMoveToHi),
      .iMoveToLo     (iMoveToLo),
      .iMoveData     (iMoveData),
      .oMduSrc0      (oMduSrc0),
      .oMduSrc1      (oMduSrc1),
      .oMduOperation (oMduOperation),
      .iMduResult    (iMduResult),
      .oHi           (oHi),
      .oLo           (oLo),
      .oBusy         (oBusy),
      .oDone         (oDone)
   );

   // MDU model: multiply yields the upper product word, divide the quotient.
   logic [63:0] prod;
   always_comb begin
      prod = {32'b0, oMduSrc0} * {32'b0, oMduSrc1};
      if (oMduOperation) begin
         iMduResult = (oMduSrc1 == 32'd0) ? 32'hFFFF_FFFF : oMduSrc0 / oMduSrc1;
      end else begin
         iMduResult = prod[63:32];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance past the next active edge and settle.
   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   // Issue an op at edge E0, then run until oDone. Returns number of busy samples
   // and the index (edges after E0) at which oDone was seen, -1 on timeout.
   task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                         output int busy_cycles, output int done_at);
      iStart = 1'b1; iOperation = op; iSrcA = a; iSrcB = b;
      tick();
      iStart = 1'b0;
      busy_cycles = 0;
      done_at = -1;
      for (int i = 0; i < 80; i++) begin
         if (oBusy) busy_cycles++;
         if (oDone) begin
            done_at = i;
            break;
         end
         tick();
      end
   endtask

   int nb, da, ndone;

   initial begin
      iReset = 1'b1; iStart = 1'b0; iOperation = 1'b0; iSrcA = '0; iSrcB = '0;
      iMoveToHi = 1'b0; iMoveToLo = 1'b0; iMoveData = '0;
      tick(); tick();
      iReset = 1'b0;
      check("rst_hi", oHi, 32'd0);
      check("rst_lo", oLo, 32'd0);
      check("rst_busy", {31'd0, oBusy}, 32'd0);
      check("rst_done", {31'd0, oDone}, 32'd0);
      check("rst_src0", oMduSrc0, 32'd0);
      check("rst_op", {31'd0, oMduOperation}, 32'd0);

      // Direct moves in IDLE.
      iMoveToHi = 1'b1; iMoveData = 32'hDEAD_BEEF;
      tick();
      iMoveToHi = 1'b0;
      check("mv_hi", oHi, 32'hDEAD_BEEF);
      iMoveToLo = 1'b1; iMoveData = 32'h1234_5678;
      tick();
      iMoveToLo = 1'b0;
      check("mv_lo", oLo, 32'h1234_5678);
      check("mv_lo_hi_kept", oHi, 32'hDEAD_BEEF);

      // Multiply 3*5: HI of product is 0, timed edge by edge.
      iStart = 1'b1; iOperation = 1'b0; iSrcA = 32'd3; iSrcB = 32'd5;
      tick();
      iStart = 1'b0; iSrcA = 32'd77; iSrcB = 32'd88;
      check("mul_e0_busy", {31'd0, oBusy}, 32'd1);
      check("mul_e0_src0", oMduSrc0, 32'd3);
      check("mul_e0_src1", oMduSrc1, 32'd5);
      check("mul_e0_hi", oHi, 32'hDEAD_BEEF);
      tick();
      check("mul_e1_busy", {31'd0, oBusy}, 32'd1);
      check("mul_e1_done", {31'd0, oDone}, 32'd0);
      check("mul_e1_hi", oHi, 32'hDEAD_BEEF);
      tick();
      check("mul_e2_hi", oHi, 32'd0);
      check("mul_e2_lo", oLo, 32'h1234_5678);
      check("mul_e2_done", {31'd0, oDone}, 32'd1);
      check("mul_e2_busy", {31'd0, oBusy}, 32'd0);
      tick();
      check("mul_e3_done", {31'd0, oDone}, 32'd0);

      // Multiply 0x10000 * 0x30000 = 0x3_0000_0000 -> HI = 3.
      run_op(1'b0, 32'h0001_0000, 32'h0003_0000, nb, da);
      check("mul2_busy_n", nb, 32'd2);
      check("mul2_done_at", da, 32'd2);
      check("mul2_hi", oHi, 32'd3);
      tick();

      // Divide 100/7 with a rejected start and a rejected move mid-flight.
      iStart = 1'b1; iOperation = 1'b1; iSrcA = 32'd100; iSrcB = 32'd7;
      tick();
      iStart = 1'b0;
      nb = 0; da = -1; ndone = 0;
      for (int i = 0; i < 60; i++) begin
         if (oBusy) nb++;
         if (oDone) begin
            ndone++;
            if (da < 0) da = i;
         end
         if (i == 4) begin
            iStart = 1'b1; iOperation = 1'b0; iSrcA = 32'd999; iSrcB = 32'd2;
            iMoveToHi = 1'b1; iMoveData = 32'hDEAD_BEEF;
         end else begin
            iStart = 1'b0; iMoveToHi = 1'b0;
         end
         tick();
      end
      check("div_busy_n", nb, 32'd35);
      check("div_done_at", da, 32'd35);
      check("div_done_n", ndone, 32'd1);
      check("div_lo", oLo, 32'd14);
      check("div_hi_kept", oHi, 32'd3);
      check("div_src0_kept", oMduSrc0, 32'd100);
      check("div_op_kept", {31'd0, oMduOperation}, 32'd1);

      // Divide by zero: model value captured as-is.
      run_op(1'b1, 32'd5, 32'd0, nb, da);
      check("dz_lo", oLo, 32'hFFFF_FFFF);
      tick();

      // Move and start together: move lands, then capture overwrites it.
      iMoveToHi = 1'b1; iMoveData = 32'h0000_AAAA;
      iStart = 1'b1; iOperation = 1'b0; iSrcA = 32'h0001_0000; iSrcB = 32'h0005_0000;
      tick();
      iMoveToHi = 1'b0; iStart = 1'b0;
      check("mvst_hi_moved", oHi, 32'h0000_AAAA);
      check("mvst_busy", {31'd0, oBusy}, 32'd1);
      tick(); tick();
      check("mvst_hi_cap", oHi, 32'd5);
      tick();

      // Reset mid-divide at E0+10, with start and move also asserted.
      iStart = 1'b1; iOperation = 1'b1; iSrcA = 32'd100; iSrcB = 32'd7;
      tick();
      iStart = 1'b0;
      for (int i = 1; i < 10; i++) tick();
      iReset = 1'b1; iStart = 1'b1; iMoveToHi = 1'b1; iMoveData = 32'h5555_5555;
      tick();
      iReset = 1'b0; iStart = 1'b0; iMoveToHi = 1'b0;
      check("rmid_busy", {31'd0, oBusy}, 32'd0);
      check("rmid_lo", oLo, 32'd0);
      check("rmid_hi", oHi, 32'd0);
      check("rmid_src0", oMduSrc0, 32'd0);
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         if (oDone) ndone++;
         if (oBusy) ndone++;
         tick();
      end
      check("rmid_no_done", ndone, 32'd0);
      check("rmid_lo_after", oLo, 32'd0);

      // Back-to-back: multiply, then divide started in the DONE cycle.
      run_op(1'b0, 32'h8000_0000, 32'd4, nb, da);
      check("b2b_mul_done_at", da, 32'd2);
      check("b2b_mul_hi", oHi, 32'd2);
      iStart = 1'b1; iOperation = 1'b1; iSrcA = 32'd50; iSrcB = 32'd5;
      tick();
      iStart = 1'b0;
      check("b2b_div_busy", {31'd0, oBusy}, 32'd1);
      check("b2b_div_src0", oMduSrc0, 32'd50);
      check("b2b_div_done", {31'd0, oDone}, 32'd0);
      da = -1;
      for (int i = 0; i < 60; i++) begin
         if (oDone) begin
            da = i;
            break;
         end
         tick();
      end
      check("b2b_div_done_at", da, 32'd35);
      check("b2b_div_lo", oLo, 32'd10);
      check("b2b_div_hi", oHi, 32'd2);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
